// File: rtl/alu_4bit.sv
// alu_4bit: registered ALU for the teaching CPU datapath.
// One operation accepted per cycle; the result (and optional flags) appear
// one clock after the operands are sampled. Synchronous active-high reset.
// Optional build macro ALU_FLAGS_EN adds the registered carry and zero flags.
module alu_4bit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
`ifdef ALU_FLAGS_EN
  output logic             carry,
  output logic             zero,
`endif
  output logic [WIDTH-1:0] C
);

  localparam int unsigned SEL_W = 4;

  localparam logic [SEL_W-1:0] OP_ADD = SEL_W'(0);
  localparam logic [SEL_W-1:0] OP_SUB = SEL_W'(1);
  localparam logic [SEL_W-1:0] OP_AND = SEL_W'(2);
  localparam logic [SEL_W-1:0] OP_OR  = SEL_W'(3);
  localparam logic [SEL_W-1:0] OP_XOR = SEL_W'(4);
  localparam logic [SEL_W-1:0] OP_EQ  = SEL_W'(5);
  localparam logic [SEL_W-1:0] OP_GT  = SEL_W'(6);
  localparam logic [SEL_W-1:0] OP_LT  = SEL_W'(7);
  localparam logic [SEL_W-1:0] OP_SHR = SEL_W'(8);
  localparam logic [SEL_W-1:0] OP_SHL = SEL_W'(9);

  logic [WIDTH-1:0] c_d;
  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] add_r;
  logic [WIDTH-1:0] sub_r;
  logic             sh_oor;

`ifdef ALU_FLAGS_EN
  logic add_co;
  logic sub_bo;
  logic carry_d;
  logic carry_q;
  logic zero_q;

  // Extended add/sub so the top bit gives carry-out / borrow.
  assign {add_co, add_r} = {1'b0, A} + {1'b0, B};
  assign {sub_bo, sub_r} = {1'b0, A} - {1'b0, B};
`else
  // Plain modulo add/sub when no flags are built.
  assign add_r = A + B;
  assign sub_r = A - B;
`endif

  // Shift amounts of WIDTH or more clear the result.
  assign sh_oor = ({1'b0, B} >= (WIDTH+1)'(WIDTH));

  // Next result selected by opcode; reserved codes yield zero.
  always_comb begin
    c_d = '0;
    case (sel)
      OP_ADD:  c_d = add_r;
      OP_SUB:  c_d = sub_r;
      OP_AND:  c_d = A & B;
      OP_OR:   c_d = A | B;
      OP_XOR:  c_d = A ^ B;
      OP_EQ:   c_d = WIDTH'(A == B);
      OP_GT:   c_d = WIDTH'(A > B);
      OP_LT:   c_d = WIDTH'(A < B);
      OP_SHR:  c_d = sh_oor ? '0 : (A >> B);
      OP_SHL:  c_d = sh_oor ? '0 : (A << B);
      default: c_d = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  // Carry only meaningful for ADD (carry-out) and SUB (borrow).
  always_comb begin
    carry_d = 1'b0;
    case (sel)
      OP_ADD:  carry_d = add_co;
      OP_SUB:  carry_d = sub_bo;
      default: carry_d = 1'b0;
    endcase
  end

  // Flag registers; zero tracks the value being loaded into C.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      carry_q <= carry_d;
      zero_q  <= (c_d == '0);
    end
  end

  assign carry = carry_q;
  assign zero  = zero_q;
`endif

  // Result register; reset takes priority over the computed value.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= '0;
    end else begin
      c_q <= c_d;
    end
  end

  assign C = c_q;

endmodule

// File: tb/tb_alu_4bit.sv
// tb_alu_4bit: scoreboard bench for alu_4bit. Stimulus pushes the expected
// response from a plain-arithmetic reference model; a monitor pops and
// compares one entry after every rising edge. Flags are checked when the
// bench is built with ALU_FLAGS_EN.
module tb_alu_4bit;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  typedef struct {
    int a;
    int b;
    int s;
    int r;
    int c;
    int cy;
    int z;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   sel;
  logic [W-1:0] C;
`ifdef ALU_FLAGS_EN
  logic         carry;
  logic         zero;
`endif

  exp_t sb_q[$];
  int   tests;
  int   fails;
  int   last_c;

  alu_4bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .sel   (sel),
`ifdef ALU_FLAGS_EN
    .carry (carry),
    .zero  (zero),
`endif
    .C     (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model straight from the operation table.
  function automatic exp_t model(input int a, input int b, input int s, input int r);
    exp_t e;
    int   t;
    e.a = a; e.b = b; e.s = s; e.r = r;
    e.c = 0; e.cy = 0;
    if (r != 0) begin
      e.c = 0; e.cy = 0;
    end else begin
      case (s)
        0: begin t = a + b; e.c = t & MASK; e.cy = (t > MASK) ? 1 : 0; end
        1: begin e.c = (a - b) & MASK; e.cy = (a < b) ? 1 : 0; end
        2: e.c = a & b;
        3: e.c = a | b;
        4: e.c = a ^ b;
        5: e.c = (a == b) ? 1 : 0;
        6: e.c = (a > b) ? 1 : 0;
        7: e.c = (a < b) ? 1 : 0;
        8: e.c = (b >= W) ? 0 : (a >> b);
        9: e.c = (b >= W) ? 0 : ((a << b) & MASK);
        default: e.c = 0;
      endcase
    end
    e.z = (e.c == 0) ? 1 : 0;
    return e;
  endfunction

  // Drive one operation at the falling edge and record its expected result.
  task automatic issue(input int a, input int b, input int s, input int r);
    @(negedge clk);
    A   = W'(a);
    B   = W'(b);
    sel = 4'(s);
    rst = (r != 0);
    sb_q.push_back(model(a, b, s, r));
  endtask

  // Monitor: one scoreboard entry retires per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        tests++;
        if (int'(C) != e.c) begin
          fails++;
          $display("FAIL result a=%0d b=%0d sel=%0d rst=%0d: C=%0d expected %0d",
                   e.a, e.b, e.s, e.r, C, e.c);
        end
`ifdef ALU_FLAGS_EN
        tests++;
        if (int'(carry) != e.cy || int'(zero) != e.z) begin
          fails++;
          $display("FAIL flags a=%0d b=%0d sel=%0d rst=%0d: carry=%0d zero=%0d expected carry=%0d zero=%0d",
                   e.a, e.b, e.s, e.r, carry, zero, e.cy, e.z);
        end
`endif
      end
    end
  end

  initial begin
    int budget;
    tests = 0;
    fails = 0;
    rst = 1'b1; A = '0; B = '0; sel = '0;

    // Reset from arbitrary inputs, load a nonzero value, reset again, release.
    issue(7, 3, 0, 1);
    issue(15, 15, 3, 0);
    issue(15, 15, 3, 1);
    issue(6, 1, 3, 0);

    // Sweep sel 0..9 with A=5, B=2.
    for (int s = 0; s < 10; s++) issue(5, 2, s, 0);

    // Wrap and borrow.
    issue(15, 1, 0, 0);
    issue(2, 5, 1, 0);
    issue(15, 0, 0, 0);

    // Compares.
    issue(9, 9, 5, 0);
    issue(9, 9, 6, 0);
    issue(9, 9, 7, 0);
    issue(3, 12, 6, 0);
    issue(3, 12, 7, 0);

    // Shift bounds.
    issue(9, 0, 8, 0);
    issue(9, 0, 9, 0);
    issue(9, 4, 8, 0);
    issue(9, 4, 9, 0);
    issue(9, 1, 9, 0);
    issue(9, 3, 8, 0);
    issue(9, 15, 9, 0);

    // Reserved codes.
    issue(15, 15, 12, 0);
    for (int s = 10; s < 16; s++) issue(s, 15 - s, s, 0);

    // Latency: inputs changed mid-cycle must not reach C before the next edge.
    issue(5, 2, 0, 0);
    last_c = 7;
    @(posedge clk);
    #2;
    A = W'(1); B = W'(1); sel = 4'd3;
    sb_q.push_back(model(1, 1, 3, 0));
    #2;
    tests++;
    if (int'(C) != last_c) begin
      fails++;
      $display("FAIL hold_early: C=%0d expected %0d", C, last_c);
    end
    @(negedge clk);
    #1;
    tests++;
    if (int'(C) != last_c) begin
      fails++;
      $display("FAIL hold_late: C=%0d expected %0d", C, last_c);
    end

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      issue(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)),
            int'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0) ? 1 : 0);
    end

    // Drain with a bounded wait.
    budget = 0;
    while (sb_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (sb_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
